// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, dead-time length and leading-zero blank mask for the scan driver
package seg7_pkg;
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam int DEAD_CYC = 16;

    // bit k set when digit k>0 and every nibble from k up to n-1 is zero
    function automatic logic [7:0] blank_mask(input logic [31:0] d, input int n);
        logic z;
        blank_mask = '0;
        z = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            if (k < n) begin
                z = z && (d[4*k +: 4] == 4'd0);
                blank_mask[k] = z;
            end
        end
    endfunction
endpackage

// File: rtl/seg7_scan_drv_if.sv
// seg7_scan_drv_if: digit load side and display pin side of the scan driver
interface seg7_scan_drv_if #(parameter int NDIG = 4);
    logic            LD;
    logic [4*NDIG-1:0] DIN;
    logic            BLANK_LZ;
    logic [6:0]      SEG;
    logic [NDIG-1:0] AN;
    logic            FRAME;
    modport master (output LD, DIN, BLANK_LZ, input SEG, AN, FRAME);
    modport slave  (input LD, DIN, BLANK_LZ, output SEG, AN, FRAME);
endinterface

// File: rtl/seg7_dec.sv
// seg7_dec: BCD nibble to active-high gfedcba pattern, dash for invalid codes
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pat
);
    always_comb begin
        pat = SEG_DASH;
        case (nib)
            4'd0: pat = SEG_0;
            4'd1: pat = SEG_1;
            4'd2: pat = SEG_2;
            4'd3: pat = SEG_3;
            4'd4: pat = SEG_4;
            4'd5: pat = SEG_5;
            4'd6: pat = SEG_6;
            4'd7: pat = SEG_7;
            4'd8: pat = SEG_8;
            4'd9: pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: multiplexed 7-segment scanner with registered outputs and leading-zero blanking.
// Define SEG7_DEADTIME_EN to blank the first DEAD_CYC cycles of every digit slot.
module seg7_scan_drv
    import seg7_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int SCAN_DIV    = 50000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    seg7_scan_drv_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NDIG);
    localparam logic [6:0]      SEG_OFF = {7{SEG_ACT_LOW}};
    localparam logic [NDIG-1:0] AN_OFF  = {NDIG{AN_ACT_LOW}};

    logic [4*NDIG-1:0] shadow;
    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic              slot_end, last_dig, blank, dead;
    logic [3:0]        nib;
    logic [6:0]        pat, seg_d;
    logic [7:0]        bmask;
    logic [NDIG-1:0]   an_d;

    assign slot_end = presc == PW'(SCAN_DIV - 1);
    assign last_dig = idx == IW'(NDIG - 1);
    assign nib      = shadow[4*int'(idx) +: 4];
    assign bmask    = blank_mask(32'(shadow), NDIG);
    assign blank    = bus.BLANK_LZ && bmask[idx];

`ifdef SEG7_DEADTIME_EN
    assign dead = 32'(presc) < DEAD_CYC;
`else
    assign dead = 1'b0;
`endif

    seg7_dec u_dec (.nib(nib), .pat(pat));

    // a blanked digit keeps its anode on; only dead-time releases the anodes
    assign seg_d = (dead || blank) ? SEG_OFF : pat ^ SEG_OFF;
    assign an_d  = dead ? AN_OFF : (NDIG'(1) << idx) ^ AN_OFF;

    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow    <= '0;
            presc     <= '0;
            idx       <= '0;
            bus.SEG   <= SEG_OFF;
            bus.AN    <= AN_OFF;
            bus.FRAME <= 1'b0;
        end else begin
            if (bus.LD) shadow <= bus.DIN;
            presc <= slot_end ? '0 : presc + 1'b1;
            if (slot_end) idx <= last_dig ? '0 : idx + 1'b1;
            bus.SEG   <= seg_d;
            bus.AN    <= an_d;
            bus.FRAME <= slot_end && last_dig;
        end
    end
endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb_seg7_scan_drv: cycle scoreboard plus directed display checks for seg7_scan_drv (NDIG=4)
module tb_seg7_scan_drv;
`ifdef SEG7_DEADTIME_EN
    localparam int SD = 20;
    localparam bit DT = 1'b1;
`else
    localparam int SD = 4;
    localparam bit DT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_fail = 0;

    seg7_scan_drv_if #(.NDIG(4)) bus ();

    seg7_scan_drv #(.NDIG(4), .SCAN_DIV(SD), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    logic [15:0] m_sh;
    int m_p, m_i;
    logic [11:0] expq [$];

    // reference model: predicts the registered outputs produced at each edge
    always @(posedge clk) begin
        logic [6:0] s;
        logic [3:0] a;
        logic f, bl, dd;
        if (rst) begin
            s = 7'd0; a = 4'd0; f = 1'b0;
            m_sh = 16'd0; m_p = 0; m_i = 0;
        end else begin
            bl = bus.BLANK_LZ && m_i != 0 && (m_sh >> (4*m_i)) == 16'd0;
            dd = DT && m_p < 16;
            s = (dd || bl) ? 7'd0 : tbl[m_sh[m_i*4 +: 4]];
            a = dd ? 4'd0 : 4'(1 << m_i);
            f = (m_p == SD-1) && (m_i == 3);
            if (bus.LD) m_sh = bus.DIN;
            if (m_p == SD-1) begin
                m_p = 0;
                m_i = (m_i + 1) % 4;
            end else m_p++;
        end
        expq.push_back({~s, ~a, f});
    end

    always @(negedge clk) begin
        logic [11:0] e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            n_chk++;
            assert ({bus.SEG, bus.AN, bus.FRAME} === e) else begin
                n_fail++;
                $error("FAIL scoreboard t=%0t seg/an/frame got %h expected %h", $time, {bus.SEG, bus.AN, bus.FRAME}, e);
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_an(input logic [3:0] want, input string tag);
        int k = 0;
        while (bus.AN !== want && k < 200) begin
            step();
            k++;
        end
        chk(tag, {4'h0, bus.AN}, {4'h0, want});
    endtask

    // waits for a fresh visit of digit d (passes the previous digit first)
    task automatic show(input int d, input logic [6:0] seg, input string tag);
        wait_an(~4'(1 << ((d + 3) % 4)), {tag, "_prev"});
        wait_an(~4'(1 << d), {tag, "_an"});
        chk(tag, {1'b0, bus.SEG}, {1'b0, seg});
    endtask

    task automatic load(input logic [15:0] v);
        bus.DIN = v;
        bus.LD = 1'b1;
        step();
        bus.LD = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.LD = 1'b0;
        bus.DIN = 16'h0;
        bus.BLANK_LZ = 1'b0;
        repeat (3) step();
        chk("rst_seg", {1'b0, bus.SEG}, 8'h7F);
        chk("rst_an", {4'h0, bus.AN}, 8'h0F);
        rst = 1'b0;
        chk("rst_hold_an", {4'h0, bus.AN}, 8'h0F);
`ifndef SEG7_DEADTIME_EN
        for (int i = 0; i < 16; i++) begin
            step();
            chk("scan_an", {4'h0, bus.AN}, {4'h0, ~4'(1 << (i / 4))});
            chk("scan_frame", {7'h0, bus.FRAME}, {7'h0, i == 15});
        end
`endif
        load(16'h1234);
        show(0, ~7'b1100110, "dec_d0_4");
        show(3, ~7'b0000110, "dec_d3_1");
        load(16'h000F);
        show(0, ~7'b1000000, "dec_dash");
        bus.BLANK_LZ = 1'b1;
        load(16'h0050);
        show(3, 7'h7F, "blk_d3");
        show(2, 7'h7F, "blk_d2");
        show(1, ~7'b1101101, "blk_d1_5");
        show(0, ~7'b0111111, "blk_d0_0");
        load(16'h0000);
        show(1, 7'h7F, "zero_d1");
        show(0, ~7'b0111111, "zero_d0");
        bus.DIN = 16'h9999;
        show(1, 7'h7F, "hold_d1");
        show(0, ~7'b0111111, "hold_d0");
        for (int k = 0; k < 200 && m_p != SD-1; k++) step();
        bus.LD = 1'b1;
        step();
        bus.LD = 1'b0;
`ifndef SEG7_DEADTIME_EN
        step();
        chk("ld_slot_seg", {1'b0, bus.SEG}, {1'b0, ~7'b1101111});
        chk("ld_slot_an_on", {7'h0, bus.AN != 4'hF}, 8'h01);
`endif
        show(2, ~7'b1101111, "ld_d2_9");
        rst = 1'b1;
        step();
        chk("mid_rst_seg", {1'b0, bus.SEG}, 8'h7F);
        chk("mid_rst_an", {4'h0, bus.AN}, 8'h0F);
        rst = 1'b0;
        step();
`ifndef SEG7_DEADTIME_EN
        chk("restart_an", {4'h0, bus.AN}, 8'h0E);
        chk("restart_seg", {1'b0, bus.SEG}, {1'b0, ~7'b0111111});
`endif
        show(1, 7'h7F, "restart_d1_blank");
`ifdef SEG7_DEADTIME_EN
        for (int k = 0; k < 200 && bus.FRAME !== 1'b1; k++) step();
        chk("dt_frame_found", {7'h0, bus.FRAME}, 8'h01);
        for (int i = 0; i < 80; i++) begin
            step();
            chk("dt_an", {4'h0, bus.AN}, (i % 20) < 16 ? 8'h0F : {4'h0, ~4'(1 << (i / 20))});
            chk("dt_frame", {7'h0, bus.FRAME}, {7'h0, i == 79});
        end
`endif
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
